// File: rtl/crc_serial_engine_pkg.sv
// Shared types and the single-bit CRC division step for the serial CRC engine.
package crc_engine_pkg;

    // Engine FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Frame modes, latched when start is accepted.
    localparam logic GEN = 1'b0;
    localparam logic CHK = 1'b1;

    // Widest CRC the step function supports.
    localparam int MAX_W = 16;

    // One polynomial-division step for a CRC of width w (2..MAX_W).
    // The incoming bit b shifts in at the LSB. The register is reduced
    // by poly whenever the bit leaving the top is set. Bits at and above
    // w are forced to zero so the result is a clean w-bit remainder.
    function automatic logic [MAX_W-1:0] crc_div_step(
        input logic [MAX_W-1:0] crc,
        input logic             b,
        input logic [MAX_W-1:0] poly,
        input int               w
    );
        logic [MAX_W-1:0] res;
        logic             msb;
        msb = crc[w-1];
        res = {crc[MAX_W-2:0], b} ^ (msb ? poly : '0);
        for (int i = 0; i < MAX_W; i++) begin
            if (i >= w) res[i] = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/crc_serial_engine_if.sv
// Bit-stream input, codeword result and status bundle of the serial CRC engine.
//
// Handshakes (both are sampled on rising gated_clk edges only):
//   bit_valid/bit_ready -- a bit transfers on an edge where both are high.
//   cw_valid/cw_ready   -- a result transfers on an edge where both are high.
//   The producer holds its payload stable while valid is high and ready is low.
interface crc_serial_engine_if #(
    parameter int CRC_W = 3,
    parameter int MSG_W = 5
);
    import crc_engine_pkg::*;

    logic                   mode;
    logic                   start;
    logic                   bit_in;
    logic                   bit_valid;
    logic                   bit_ready;
    logic [MSG_W+CRC_W-1:0] cw_out;
    logic                   cw_valid;
    logic                   cw_ready;
    logic [CRC_W-1:0]       crc_out;
    logic                   crc_ok;
    logic                   busy;
    state_t                 state_dbg;

    // Side that feeds bits and consumes results.
    modport master (
        output mode, start, bit_in, bit_valid, cw_ready,
        input  bit_ready, cw_out, cw_valid, crc_out, crc_ok, busy, state_dbg
    );

    // The engine.
    modport slave (
        input  mode, start, bit_in, bit_valid, cw_ready,
        output bit_ready, cw_out, cw_valid, crc_out, crc_ok, busy, state_dbg
    );

endinterface

// File: rtl/crc_step.sv
// Combinational single-bit CRC division step (crc, b -> crc_next).
module crc_step
    import crc_engine_pkg::*;
#(
    parameter int               CRC_W = 3,
    parameter logic [CRC_W-1:0] POLY  = 3'b011
) (
    input  logic [CRC_W-1:0] crc,
    input  logic             b,
    output logic [CRC_W-1:0] crc_next
);

    // Reduce by POLY when the outgoing MSB is set, shifting b in at the bottom.
    always_comb begin
        crc_next = CRC_W'(crc_div_step(MAX_W'(crc), b, MAX_W'(POLY), CRC_W));
    end

endmodule

// File: rtl/crc_serial_engine.sv
// Serial CRC generator/checker: MSB-first bit stream in, codeword and remainder out.
module crc_serial_engine
    import crc_engine_pkg::*;
#(
    parameter int               CRC_W = 3,
    parameter int               MSG_W = 5,
    parameter logic [CRC_W-1:0] POLY  = 3'b011,
    parameter logic [CRC_W-1:0] INIT  = '0
) (
    input  logic                 gated_clk,
    input  logic                 reset,
    crc_serial_engine_if.slave   bus
);

    localparam int TW = MSG_W + CRC_W;
    localparam int CW = $clog2(TW + 1);

    // Count values on which the last bit of each phase is taken.
    localparam logic [CW-1:0] GEN_LAST = CW'(MSG_W - 1);
    localparam logic [CW-1:0] CHK_LAST = CW'(TW - 1);
    localparam logic [CW-1:0] PAD_LAST = CW'(CRC_W - 1);

    state_t           state;
    logic             mode_q;
    logic [CW-1:0]    cnt;
    logic [CRC_W-1:0] crc;
    logic [TW-1:0]    shreg;

    logic             bit_ready_q;
    logic [TW-1:0]    cw_out_q;
    logic             cw_valid_q;
    logic [CRC_W-1:0] crc_out_q;
    logic             crc_ok_q;
    logic             busy_q;

    logic             step_b;
    logic [CRC_W-1:0] crc_next;
    logic [TW-1:0]    shreg_next;

    // PAD feeds the augmentation zeros; otherwise the live stream bit.
    assign step_b     = (state == PAD) ? 1'b0 : bus.bit_in;
    assign shreg_next = {shreg[TW-2:0], bus.bit_in};

    crc_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .crc      (crc),
        .b        (step_b),
        .crc_next (crc_next)
    );

    // Frame sequencer; every output is a register updated alongside the state.
    always_ff @(posedge gated_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mode_q      <= GEN;
            cnt         <= '0;
            crc         <= '0;
            shreg       <= '0;
            bit_ready_q <= 1'b0;
            cw_out_q    <= '0;
            cw_valid_q  <= 1'b0;
            crc_out_q   <= '0;
            crc_ok_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        crc         <= INIT;
                        cnt         <= '0;
                        shreg       <= '0;
                        mode_q      <= bus.mode;
                        state       <= SHIFT;
                        bit_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bus.bit_valid) begin
                        crc   <= crc_next;
                        shreg <= shreg_next;
                        cnt   <= cnt + 1'b1;
                        if (mode_q == GEN && cnt == GEN_LAST) begin
                            state       <= PAD;
                            cnt         <= '0;
                            bit_ready_q <= 1'b0;
                        end else if (mode_q == CHK && cnt == CHK_LAST) begin
                            state       <= DONE;
                            bit_ready_q <= 1'b0;
                            cw_valid_q  <= 1'b1;
                            cw_out_q    <= shreg_next;
                            crc_out_q   <= crc_next;
                            crc_ok_q    <= (crc_next == '0);
                        end
                    end
                end
                PAD: begin
                    crc <= crc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == PAD_LAST) begin
                        state      <= DONE;
                        cw_valid_q <= 1'b1;
                        cw_out_q   <= {shreg[MSG_W-1:0], crc_next};
                        crc_out_q  <= crc_next;
                        crc_ok_q   <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.cw_ready) begin
                        state      <= IDLE;
                        cw_valid_q <= 1'b0;
                        cw_out_q   <= '0;
                        crc_out_q  <= '0;
                        crc_ok_q   <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.bit_ready = bit_ready_q;
    assign bus.cw_out    = cw_out_q;
    assign bus.cw_valid  = cw_valid_q;
    assign bus.crc_out   = crc_out_q;
    assign bus.crc_ok    = crc_ok_q;
    assign bus.busy      = busy_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_crc_serial_engine.sv
// Directed bench for crc_serial_engine: a default (CRC-3, 5-bit) instance and a CRC-8 instance.
module tb_crc_serial_engine;
    import crc_engine_pkg::*;

    logic gated_clk = 1'b0;
    logic reset     = 1'b1;

    // Shared stimulus; each instance has its own start.
    logic mode      = 1'b0;
    logic start_a   = 1'b0;
    logic start_b   = 1'b0;
    logic bit_in    = 1'b0;
    logic bit_valid = 1'b0;
    logic cw_ready  = 1'b0;
    logic sel       = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    crc_serial_engine_if #(.CRC_W(3), .MSG_W(5)) bus_a ();
    crc_serial_engine_if #(.CRC_W(8), .MSG_W(8)) bus_b ();

    assign bus_a.mode      = mode;
    assign bus_a.start     = start_a;
    assign bus_a.bit_in    = bit_in;
    assign bus_a.bit_valid = bit_valid;
    assign bus_a.cw_ready  = cw_ready;
    assign bus_b.mode      = mode;
    assign bus_b.start     = start_b;
    assign bus_b.bit_in    = bit_in;
    assign bus_b.bit_valid = bit_valid;
    assign bus_b.cw_ready  = cw_ready;

    crc_serial_engine u_a (
        .gated_clk (gated_clk),
        .reset     (reset),
        .bus       (bus_a)
    );

    crc_serial_engine #(
        .CRC_W (8),
        .MSG_W (8),
        .POLY  (8'h07),
        .INIT  (8'h00)
    ) u_b (
        .gated_clk (gated_clk),
        .reset     (reset),
        .bus       (bus_b)
    );

    // Clock
    always #5 gated_clk = ~gated_clk;

    // Outputs of the instance under test, widened to a common width.
    logic [15:0] o_cw;
    logic [15:0] o_crc;
    logic        o_valid, o_ok, o_busy, o_ready;
    always_comb begin
        o_cw    = sel ? bus_b.cw_out  : {8'h00, bus_a.cw_out};
        o_crc   = sel ? {8'h00, bus_b.crc_out} : {13'h0, bus_a.crc_out};
        o_valid = sel ? bus_b.cw_valid  : bus_a.cw_valid;
        o_ok    = sel ? bus_b.crc_ok    : bus_a.crc_ok;
        o_busy  = sel ? bus_b.busy      : bus_a.busy;
        o_ready = sel ? bus_b.bit_ready : bus_a.bit_ready;
    end

    typedef struct {
        logic        sel;
        logic        mode;
        logic [15:0] word;
        int          nbits;
        logic [15:0] exp_cw;
        logic [15:0] exp_crc;
        logic        exp_ok;
        int          exp_lat;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_cw"},    o_cw,           16'h0);
        check({name, "_crc"},   o_crc,          16'h0);
        check({name, "_valid"}, {15'h0, o_valid}, 16'h0);
        check({name, "_ok"},    {15'h0, o_ok},    16'h0);
        check({name, "_busy"},  {15'h0, o_busy},  16'h0);
        check({name, "_ready"}, {15'h0, o_ready}, 16'h0);
    endtask

    // Driver tasks: inputs change on negedges, DUT samples on posedges.
    task automatic start_frame(input logic s, input logic m);
        sel  = s;
        mode = m;
        if (s) start_b = 1'b1;
        else   start_a = 1'b1;
        @(negedge gated_clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(negedge gated_clk);
        bit_valid = 1'b0;
    endtask

    // Counts edges until cw_valid, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!o_valid && lat < 40) begin
            @(negedge gated_clk);
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        start_frame(v.sel, v.mode);
        check({name, "_busy"},  {15'h0, o_busy},  16'h1);
        check({name, "_ready"}, {15'h0, o_ready}, 16'h1);
        for (int i = v.nbits - 1; i >= 0; i--) send_bit(v.word[i]);
        wait_done(lat);
        check({name, "_latency"}, 16'(lat), 16'(v.exp_lat));
        check({name, "_valid"}, {15'h0, o_valid}, 16'h1);
        check({name, "_cw"},  o_cw,  v.exp_cw);
        check({name, "_crc"}, o_crc, v.exp_crc);
        check({name, "_ok"},  {15'h0, o_ok}, {15'h0, v.exp_ok});
        cw_ready = 1'b1;
        @(negedge gated_clk);
        cw_ready = 1'b0;
        check_idle({name, "_after"});
        @(negedge gated_clk);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        // sel mode word nbits exp_cw exp_crc exp_ok exp_lat
        tbl[0] = '{1'b0, GEN, 16'h001A, 5,  16'h00D2, 16'h0002, 1'b0, 3};
        tbl[1] = '{1'b0, CHK, 16'h00D2, 8,  16'h00D2, 16'h0000, 1'b1, 0};
        tbl[2] = '{1'b0, CHK, 16'h00D3, 8,  16'h00D3, 16'h0001, 1'b0, 0};
        tbl[3] = '{1'b0, GEN, 16'h0001, 5,  16'h000B, 16'h0003, 1'b0, 3};
        tbl[4] = '{1'b0, GEN, 16'h0010, 5,  16'h0081, 16'h0001, 1'b0, 3};
        tbl[5] = '{1'b0, CHK, 16'h000B, 8,  16'h000B, 16'h0000, 1'b1, 0};
        tbl[6] = '{1'b0, CHK, 16'h0080, 8,  16'h0080, 16'h0001, 1'b0, 0};
        tbl[7] = '{1'b0, GEN, 16'h001F, 5,  16'h00FE, 16'h0006, 1'b0, 3};
        tbl[8] = '{1'b1, GEN, 16'h0031, 8,  16'h3197, 16'h0097, 1'b0, 8};
        tbl[9] = '{1'b1, CHK, 16'h3197, 16, 16'h3197, 16'h0000, 1'b1, 0};

        // Reset state of both instances.
        reset = 1'b1;
        repeat (2) @(negedge gated_clk);
        sel = 1'b0;
        #1 check_idle("reset_a");
        sel = 1'b1;
        #1 check_idle("reset_b");
        reset = 1'b0;
        @(negedge gated_clk);

        // Table-driven frames.
        for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Generate with a 3-cycle input gap and a 4-cycle consumer stall.
        start_frame(1'b0, GEN);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge gated_clk);
            check("gap_ready", {15'h0, o_ready}, 16'h1);
            check("gap_valid", {15'h0, o_valid}, 16'h0);
        end
        send_bit(1'b1);
        send_bit(1'b0);
        wait_done(lat);
        check("gap_latency", 16'(lat), 16'd3);
        for (int i = 0; i < 4; i++) begin
            check("stall_cw",    o_cw,  16'h00D2);
            check("stall_crc",   o_crc, 16'h0002);
            check("stall_valid", {15'h0, o_valid}, 16'h1);
            @(negedge gated_clk);
        end
        // start presented with the consuming edge must be ignored.
        cw_ready = 1'b1;
        start_a  = 1'b1;
        @(negedge gated_clk);
        cw_ready = 1'b0;
        start_a  = 1'b0;
        check_idle("handshake_start");
        @(negedge gated_clk);
        check("still_idle_busy", {15'h0, o_busy}, 16'h0);

        // Reset after 3 data bits aborts the frame at once.
        start_frame(1'b0, GEN);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b1;
        #1 check_idle("midreset");
        @(negedge gated_clk);
        check_idle("midreset_hold");
        reset = 1'b0;
        @(negedge gated_clk);
        run_vec(tbl[0], "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/crc_serial_engine.md
# crc_serial_engine

Parametrised serial CRC generator/checker, the successor to the fixed 3-bit, 5-bit-message CRC block. It accepts a message MSB-first over a valid/ready bit stream. In generate mode it appends CRC_W augmentation zeros internally and presents the codeword. In check mode it divides a received codeword and flags a zero remainder. It sits downstream of the design's latch-based clock gate and runs only on gated clock edges.

## Interface
Parameters:
- CRC_W, 3: CRC width; legal range 2..16.
- MSG_W, 5: message bits per frame; legal range 1..32.
- POLY, 3'b011: generator polynomial, low CRC_W bits; the x^CRC_W term is implicit. Default is x^3+x+1.
- INIT, 0: CRC register value loaded at frame start.

Ports:
- gated_clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- mode  in  1  0 = generate, 1 = check; sampled only when start is accepted
- start  in  1  frame start; accepted only in IDLE
- bit_in  in  1  serial data, MSB-first
- bit_valid  in  1  bit_in is valid
- bit_ready  out  1  engine consumes bit_in on this edge if bit_valid
- cw_out  out  MSG_W+CRC_W  generate: {msg, crc}; check: received word. Zero unless cw_valid.
- cw_valid  out  1  result available
- cw_ready  in  1  consumer takes the result
- crc_out  out  CRC_W  final remainder; zero unless cw_valid
- crc_ok  out  1  check mode only, remainder == 0; zero unless cw_valid
- busy  out  1  state != IDLE

## Operation
- Division step, applied per shifted bit b: crc <= {crc[CRC_W-2:0], b} ^ (crc[CRC_W-1] ? POLY : 0).
- FSM states:
  - IDLE: start accepted; load crc=INIT, cnt=0, shreg=0; latch mode; go to SHIFT.
  - SHIFT: bit_ready=1. Each edge with bit_valid: apply the step with bit_in, shift bit_in into shreg, cnt+1.
    - Generate: after accepting bit MSG_W, go to PAD with cnt cleared.
    - Check: after accepting bit MSG_W+CRC_W, go to DONE.
  - PAD (generate only): bit_ready=0; apply the step with b=0 on each edge; after CRC_W edges go to DONE.
  - DONE: cw_valid=1; outputs held stable. The edge with cw_ready goes to IDLE.
- cw_out in generate mode = {shreg[MSG_W-1:0], crc}.
- cw_out in check mode = shreg[MSG_W+CRC_W-1:0]; crc_ok = (crc == 0).
- cnt width = $clog2(MSG_W+CRC_W+1).
- start outside IDLE is ignored.
- A bit_valid gap stalls SHIFT; state and crc are unchanged.

## Timing
- All outputs are registered. Reset value of every output is 0, and the FSM resets to IDLE.
- Reset asserted mid-frame aborts the frame immediately (asynchronous); no partial result is ever presented.
- Generate latency with no stalls: cw_valid rises after the edge start+1+MSG_W+CRC_W. With the defaults: start edge, 5 data edges, 3 pad edges, DONE visible after the 9th edge.
- Check latency with no stalls: cw_valid rises after start+1+MSG_W+CRC_W accepted-bit edges.
- cw_valid and cw_ready on the same edge: result consumed, next state IDLE. start on that edge is ignored; a new frame requires start in IDLE.
- Back-to-back frames: minimum of one IDLE cycle between the DONE handshake and the next start.
- Gated-off clock: the engine freezes. The handshake is defined per gated_clk edge only; the upstream gate must not remove edges mid-handshake.

## Structure
- Package crc_engine_pkg holds:
  - the FSM state enum (IDLE, SHIFT, PAD, DONE);
  - the mode constants (GEN=0, CHK=1);
  - a function for the division step parameterised by width and polynomial.
- One combinational sub-module, crc_step, performs the single-bit division step (crc, b, POLY -> crc_next). It is reusable for a future parallel-bit variant.

## Test plan
- Defaults, generate, msg 5'b11010 with bit_valid held high -> crc_out=3'b010, cw_out=8'hD2, cw_valid after the 9th edge.
- Defaults, check, word 8'hD2 streamed -> crc_out=0, crc_ok=1, cw_out=8'hD2.
- Defaults, check, word 8'hD3 (single-bit error) -> crc_out=3'b001, crc_ok=0.
- Generate with bit_valid deasserted for 3 cycles mid-message, and cw_ready held low for 4 cycles in DONE -> same 8'hD2; outputs stable while stalled; IDLE one edge after cw_ready.
- Reset asserted after 3 data bits -> all outputs 0, busy=0. A fresh 5'b11010 frame then yields 8'hD2.
- CRC_W=8, POLY=8'h07, MSG_W=8, INIT=0, generate msg 8'h31 -> crc_out=8'h97, cw_out=16'h3197. Check of 16'h3197 -> crc_ok=1.
